// File: rtl/prefetcher_queue_ctrl.sv
// ---------------------------------------------------------------------------
// prefetcher_queue_ctrl
//
// Scheduler in front of the prefetcherData queue's single request port.
// Four requesters share the one opcode-per-cycle port with fixed priority:
//   DRAM read data (writeResp, 4) > invalidate (1) > CPU lookup (read, 2)
//   > internal stride prefetcher (writeReq, 3).
// The stride prefetch FSM (IDLE -> ISSUE -> WAIT -> CHECK -> AR) allocates a
// queue entry per block, checks the queue's verdict, and only then issues
// the AXI AR for entries the queue accepted.
//
// Ports
//   clk, resetN                      clock, asynchronous active-low reset
//   r_valid/r_addr/r_data, r_ready   DRAM read data for a block (always accepted)
//   inv_valid/inv_addr, inv_ready    invalidate request
//   cpu_valid/cpu_addr, cpu_ready    CPU lookup request
//   trig_valid/trig_addr, trig_ready prefetch trigger (accepted only in IDLE)
//   crs_stride/depth/maxOutstanding  prefetch configuration (sampled live)
//   q_reqOpcode/q_reqAddr/q_reqData  registered request to the queue
//   q_outstandingReqCnt/q_almostFull/q_errorCode  queue status
//   ar_valid/ar_addr, ar_ready       AXI read address channel
//   busy                             prefetch FSM not idle
//   dupSkipCnt                       saturating count of rejected prefetches
// ---------------------------------------------------------------------------
module prefetcher_queue_ctrl #(
    parameter int LOG_QUEUE_SIZE       = 6,
    parameter int LOG_BLOCK_DATA_BYTES = 6,
    parameter int ADDR_BITS            = 64,
    localparam int BLOCK_BITS          = 8 << LOG_BLOCK_DATA_BYTES
) (
    input  logic                      clk,
    input  logic                      resetN,

    input  logic                      r_valid,
    input  logic [ADDR_BITS-1:0]      r_addr,
    input  logic [BLOCK_BITS-1:0]     r_data,
    output logic                      r_ready,

    input  logic                      inv_valid,
    input  logic [ADDR_BITS-1:0]      inv_addr,
    output logic                      inv_ready,

    input  logic                      cpu_valid,
    input  logic [ADDR_BITS-1:0]      cpu_addr,
    output logic                      cpu_ready,

    input  logic                      trig_valid,
    input  logic [ADDR_BITS-1:0]      trig_addr,
    output logic                      trig_ready,

    input  logic [15:0]               crs_stride,
    input  logic [7:0]                crs_depth,
    input  logic [LOG_QUEUE_SIZE:0]   crs_maxOutstanding,

    output logic [2:0]                q_reqOpcode,
    output logic [ADDR_BITS-1:0]      q_reqAddr,
    output logic [BLOCK_BITS-1:0]     q_reqData,
    input  logic [LOG_QUEUE_SIZE:0]   q_outstandingReqCnt,
    input  logic                      q_almostFull,
    input  logic [1:0]                q_errorCode,

    output logic                      ar_valid,
    output logic [ADDR_BITS-1:0]      ar_addr,
    input  logic                      ar_ready,

    output logic                      busy,
    output logic [15:0]               dupSkipCnt
);

    localparam logic [2:0] OP_NOP        = 3'd0;
    localparam logic [2:0] OP_INVALIDATE = 3'd1;
    localparam logic [2:0] OP_READ       = 3'd2;
    localparam logic [2:0] OP_WRITE_REQ  = 3'd3;
    localparam logic [2:0] OP_WRITE_RESP = 3'd4;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        CHECK,
        AR
    } state_t;

    state_t                  stateReg, stateNext;
    logic [ADDR_BITS-1:0]    nextAddrReg, nextAddrNext;
    logic [ADDR_BITS-1:0]    stepBytesReg, stepBytesNext;
    logic [7:0]              kReg, kNext;
    logic [15:0]             dupSkipCntReg, dupSkipCntNext;

    logic [2:0]              qOpcodeReg, qOpcodeNext;
    logic [ADDR_BITS-1:0]    qAddrReg, qAddrNext;
    logic [BLOCK_BITS-1:0]   qDataReg, qDataNext;

    // Mask that clears the byte-within-block bits of an address.
    logic [ADDR_BITS-1:0]    alignMask;
    genvar gi;
    generate
        for (gi = 0; gi < ADDR_BITS; gi++) begin : gen_align_mask
            assign alignMask[gi] = (gi >= LOG_BLOCK_DATA_BYTES);
        end
    endgenerate

    logic [ADDR_BITS-1:0]    trigBase;
    logic [ADDR_BITS-1:0]    strideSext;
    logic [ADDR_BITS-1:0]    strideBytes;
    logic [8:0]              kPlusOne;
    logic                    doAdvance;

    assign trigBase    = trig_addr & alignMask;
    assign strideSext  = {{(ADDR_BITS-16){crs_stride[15]}}, crs_stride};
    assign strideBytes = strideSext << LOG_BLOCK_DATA_BYTES;
    assign kPlusOne    = {1'b0, kReg} + 9'd1;

    // -----------------------------------------------------------------------
    // Arbitration: readies are purely combinational on the valids.
    // -----------------------------------------------------------------------
    logic rGrant, invGrant, cpuGrant, pfGrant;

    assign r_ready   = 1'b1;
    assign inv_ready = !r_valid;
    assign cpu_ready = !r_valid && !inv_valid;

    assign rGrant   = r_valid;
    assign invGrant = inv_valid && !r_valid;
    assign cpuGrant = cpu_valid && !r_valid && !inv_valid;
    assign pfGrant  = !r_valid && !inv_valid && !cpu_valid
                    && (stateReg == ISSUE) && !q_almostFull
                    && (q_outstandingReqCnt < crs_maxOutstanding);

    // Request register: an idle cycle sends NOP but keeps addr/data so the
    // port does not toggle needlessly.
    always_comb begin
        qOpcodeNext = OP_NOP;
        qAddrNext   = qAddrReg;
        qDataNext   = qDataReg;
        if (rGrant) begin
            qOpcodeNext = OP_WRITE_RESP;
            qAddrNext   = r_addr & alignMask;
            qDataNext   = r_data;
        end else if (invGrant) begin
            qOpcodeNext = OP_INVALIDATE;
            qAddrNext   = inv_addr & alignMask;
        end else if (cpuGrant) begin
            qOpcodeNext = OP_READ;
            qAddrNext   = cpu_addr & alignMask;
        end else if (pfGrant) begin
            qOpcodeNext = OP_WRITE_REQ;
            qAddrNext   = nextAddrReg;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            qOpcodeReg <= OP_NOP;
            qAddrReg   <= '0;
            qDataReg   <= '0;
        end else begin
            qOpcodeReg <= qOpcodeNext;
            qAddrReg   <= qAddrNext;
            qDataReg   <= qDataNext;
        end
    end

    assign q_reqOpcode = qOpcodeReg;
    assign q_reqAddr   = qAddrReg;
    assign q_reqData   = qDataReg;

    // -----------------------------------------------------------------------
    // Stride prefetch FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            stateReg      <= IDLE;
            nextAddrReg   <= '0;
            stepBytesReg  <= '0;
            kReg          <= '0;
            dupSkipCntReg <= '0;
        end else begin
            stateReg      <= stateNext;
            nextAddrReg   <= nextAddrNext;
            stepBytesReg  <= stepBytesNext;
            kReg          <= kNext;
            dupSkipCntReg <= dupSkipCntNext;
        end
    end

    always_comb begin
        stateNext      = stateReg;
        nextAddrNext   = nextAddrReg;
        stepBytesNext  = stepBytesReg;
        kNext          = kReg;
        dupSkipCntNext = dupSkipCntReg;
        doAdvance      = 1'b0;

        case (stateReg)
            IDLE: begin
                if (trig_valid && (crs_depth != 8'd0)) begin
                    stepBytesNext = strideBytes;
                    nextAddrNext  = trigBase + strideBytes;
                    kNext         = '0;
                    stateNext     = ISSUE;
                end
            end
            ISSUE: begin
                if (pfGrant) begin
                    stateNext = WAIT;
                end
            end
            // The queue acts on the registered writeReq during this cycle.
            WAIT: begin
                stateNext = CHECK;
            end
            // Only this block issues writeReq, so a nonzero error here is the
            // verdict on our own entry; rejected entries never reach AR.
            CHECK: begin
                if (q_errorCode != 2'd0) begin
                    if (dupSkipCntReg != 16'hFFFF) begin
                        dupSkipCntNext = dupSkipCntReg + 16'd1;
                    end
                    doAdvance = 1'b1;
                end else begin
                    stateNext = AR;
                end
            end
            AR: begin
                if (ar_ready) begin
                    doAdvance = 1'b1;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase

        // ">=" rather than "==" so a depth lowered mid-burst still terminates
        // promptly instead of running until k wraps.
        if (doAdvance) begin
            kNext        = kPlusOne[7:0];
            nextAddrNext = nextAddrReg + stepBytesReg;
            stateNext    = (kPlusOne >= {1'b0, crs_depth}) ? IDLE : ISSUE;
        end
    end

    // ar_addr comes straight from nextAddrReg, which only moves on advance,
    // so it is stable for the whole AR handshake.
    assign ar_valid   = (stateReg == AR);
    assign ar_addr    = nextAddrReg;
    assign busy       = (stateReg != IDLE);
    assign trig_ready = (stateReg == IDLE);
    assign dupSkipCnt = dupSkipCntReg;

endmodule
